// File: rtl/conv_addr_fsm.sv
// Address and control sequencer for one 2D-convolution image-column buffer.
// Three passes share the column memories: LOAD writes host columns, PROC
// streams them through the convolver pipeline and stores the results, and
// READ walks the stored results once per convolver channel.
// All outputs are registered; next-state values come from one combinational block.

module conv_addr_fsm #(
    parameter int unsigned NB_ADDRESS = 10,
    parameter int unsigned NB_IMAGE   = 10,
    parameter int unsigned N_CONV     = 2,
    parameter int unsigned LATENCIA   = 5,
    parameter int unsigned NB_CH      = (N_CONV > 1) ? $clog2(N_CONV) : 1
) (
    input  logic                  i_CLK,
    input  logic                  i_reset,
    input  logic [NB_IMAGE-1:0]   i_imgLength,
    input  logic                  i_load,
    input  logic                  i_SoP,
    input  logic                  i_valid,
    output logic [NB_ADDRESS-1:0] o_writeAdd,
    output logic [NB_ADDRESS-1:0] o_readAdd,
    output logic                  o_wrEn,
    output logic                  o_convVld,
    output logic                  o_sopross,
    output logic                  o_changeBlock,
    output logic                  o_EoP,
    output logic [NB_CH-1:0]      o_readCh,
    output logic                  o_err,
    output logic [2:0]            o_state
);

    // Common width for length arithmetic so L-1 / L-3 never truncate.
    localparam int unsigned NB_W    = ((NB_IMAGE > NB_ADDRESS) ? NB_IMAGE : NB_ADDRESS) + 1;
    localparam int unsigned NB_CNT  = NB_ADDRESS + 1;
    localparam int unsigned NB_PEND = $clog2(N_CONV + 1);

    typedef enum logic [2:0] {
        StIdle = 3'b000,
        StLoad = 3'b001,
        StProc = 3'b010,
        StDone = 3'b011,
        StRead = 3'b100
    } state_e;

    state_e                state_q, state_d;
    logic [NB_IMAGE-1:0]   len_q, len_d;
    logic [NB_ADDRESS-1:0] wcnt_q, wcnt_d;
    logic [NB_ADDRESS-1:0] rcnt_q, rcnt_d;
    logic [NB_CNT-1:0]     c_q, c_d;
    logic [NB_PEND-1:0]    pend_q, pend_d;
    logic                  valid_prev_q, valid_prev_d;

    logic [NB_ADDRESS-1:0] write_add_q, write_add_d;
    logic [NB_ADDRESS-1:0] read_add_q, read_add_d;
    logic                  wr_en_q, wr_en_d;
    logic                  conv_vld_q, conv_vld_d;
    logic                  sopross_q, sopross_d;
    logic                  change_block_q, change_block_d;
    logic                  eop_q, eop_d;
    logic [NB_CH-1:0]      read_ch_q, read_ch_d;
    logic                  err_q, err_d;

    logic                  valid_edge;
    logic                  len_short;
    logic [NB_W-1:0]       len_m1;
    logic [NB_W-1:0]       len_m3;
    logic [NB_CNT-1:0]     c_next;
    logic                  proc_last;

    // Derived helpers shared by several states.
    always_comb begin
        valid_edge = i_valid & ~valid_prev_q;
        len_short  = (i_imgLength < NB_IMAGE'(4));
        len_m1     = NB_W'(len_q) - NB_W'(1);
        len_m3     = NB_W'(len_q) - NB_W'(3);
        // Cycle counter saturates instead of wrapping back into the address range.
        c_next     = (&c_q) ? c_q : c_q + NB_CNT'(1);
        // Current cycle carries the final PROC write.
        proc_last  = wr_en_q && (NB_W'(write_add_q) == len_m3);
    end

    // Next-state and next-output computation for the sequencer.
    always_comb begin
        state_d        = state_q;
        len_d          = len_q;
        wcnt_d         = wcnt_q;
        rcnt_d         = rcnt_q;
        c_d            = c_q;
        pend_d         = pend_q;
        valid_prev_d   = i_valid;
        write_add_d    = write_add_q;
        read_add_d     = read_add_q;
        read_ch_d      = read_ch_q;
        wr_en_d        = 1'b0;
        conv_vld_d     = 1'b0;
        sopross_d      = 1'b0;
        change_block_d = 1'b0;
        err_d          = 1'b0;

        unique case (state_q)
            StIdle: begin
                wcnt_d      = '0;
                rcnt_d      = '0;
                c_d         = '0;
                write_add_d = '0;
                read_add_d  = '0;
                if (pend_q == '0) begin
                    if (i_load && i_SoP) begin
                        err_d = 1'b1;
                    end else if (i_load || i_SoP) begin
                        if (len_short) begin
                            err_d = 1'b1;
                        end else begin
                            len_d = i_imgLength;
                            if (i_load) begin
                                state_d = StLoad;
                            end else begin
                                state_d    = StProc;
                                sopross_d  = 1'b1;
                                conv_vld_d = 1'b1;
                            end
                        end
                    end
                end else if (!i_load && !i_SoP) begin
                    // Requests while read-backs are pending are silently ignored.
                    state_d = StRead;
                end
            end

            StLoad: begin
                write_add_d = wcnt_q;
                if (valid_edge) begin
                    wr_en_d = 1'b1;
                    if (NB_W'(wcnt_q) == len_m1) begin
                        change_block_d = 1'b1;
                        wcnt_d         = '0;
                        state_d        = StIdle;
                    end else begin
                        wcnt_d = wcnt_q + NB_ADDRESS'(1);
                    end
                end
            end

            StProc: begin
                if (proc_last) begin
                    change_block_d = 1'b1;
                    pend_d         = NB_PEND'(N_CONV);
                    read_ch_d      = '0;
                    state_d        = StDone;
                end else begin
                    sopross_d  = 1'b1;
                    conv_vld_d = 1'b1;
                    c_d        = c_next;
                    // Read address follows the cycle count and parks on the last column.
                    read_add_d = (NB_W'(c_next) >= len_m1) ? len_m1[NB_ADDRESS-1:0]
                                                           : c_next[NB_ADDRESS-1:0];
                    if (c_next >= NB_CNT'(LATENCIA)) begin
                        wr_en_d     = 1'b1;
                        write_add_d = wcnt_q;
                        wcnt_d      = wcnt_q + NB_ADDRESS'(1);
                    end
                end
            end

            StDone: begin
                if (!i_SoP) begin
                    state_d = StIdle;
                end
            end

            StRead: begin
                if (valid_edge) begin
                    if (NB_W'(rcnt_q) == len_m3) begin
                        change_block_d = 1'b1;
                        pend_d         = pend_q - NB_PEND'(1);
                        read_ch_d      = read_ch_q + NB_CH'(1);
                        rcnt_d         = '0;
                        read_add_d     = '0;
                        state_d        = StIdle;
                    end else begin
                        rcnt_d     = rcnt_q + NB_ADDRESS'(1);
                        read_add_d = rcnt_q + NB_ADDRESS'(1);
                    end
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase

        eop_d = (pend_d != '0);
    end

    // State, counters and registered outputs; reset clears everything.
    always_ff @(posedge i_CLK or negedge i_reset) begin
        if (!i_reset) begin
            state_q        <= StIdle;
            len_q          <= '0;
            wcnt_q         <= '0;
            rcnt_q         <= '0;
            c_q            <= '0;
            pend_q         <= '0;
            valid_prev_q   <= 1'b0;
            write_add_q    <= '0;
            read_add_q     <= '0;
            wr_en_q        <= 1'b0;
            conv_vld_q     <= 1'b0;
            sopross_q      <= 1'b0;
            change_block_q <= 1'b0;
            eop_q          <= 1'b0;
            read_ch_q      <= '0;
            err_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            len_q          <= len_d;
            wcnt_q         <= wcnt_d;
            rcnt_q         <= rcnt_d;
            c_q            <= c_d;
            pend_q         <= pend_d;
            valid_prev_q   <= valid_prev_d;
            write_add_q    <= write_add_d;
            read_add_q     <= read_add_d;
            wr_en_q        <= wr_en_d;
            conv_vld_q     <= conv_vld_d;
            sopross_q      <= sopross_d;
            change_block_q <= change_block_d;
            eop_q          <= eop_d;
            read_ch_q      <= read_ch_d;
            err_q          <= err_d;
        end
    end

    // Output ports are direct flop outputs.
    always_comb begin
        o_writeAdd    = write_add_q;
        o_readAdd     = read_add_q;
        o_wrEn        = wr_en_q;
        o_convVld     = conv_vld_q;
        o_sopross     = sopross_q;
        o_changeBlock = change_block_q;
        o_EoP         = eop_q;
        o_readCh      = read_ch_q;
        o_err         = err_q;
        o_state       = state_q;
    end

endmodule

// File: tb/tb_conv_addr_fsm.sv
// Bench for conv_addr_fsm: directed stimulus with a negedge scoreboard monitor
// for write strobes, block pulses, error pulses and PROC read addresses.

module tb_conv_addr_fsm;

    localparam int unsigned NB_ADDRESS = 10;
    localparam int unsigned NB_IMAGE   = 10;
    localparam int unsigned N_CONV     = 2;
    localparam int unsigned LATENCIA   = 5;
    localparam int unsigned NB_CH      = 1;

    logic                  clk;
    logic                  rst_n;
    logic [NB_IMAGE-1:0]   img_len;
    logic                  load;
    logic                  sop;
    logic                  valid;
    logic [NB_ADDRESS-1:0] write_add;
    logic [NB_ADDRESS-1:0] read_add;
    logic                  wr_en;
    logic                  conv_vld;
    logic                  sopross;
    logic                  change_block;
    logic                  eop;
    logic [NB_CH-1:0]      read_ch;
    logic                  err;
    logic [2:0]            state;

    int checks   = 0;
    int failures = 0;
    bit mon_en   = 1'b0;

    int wr_q[$];    // expected write addresses
    int cb_q[$];    // expected state during each change-block pulse
    int err_q[$];   // expected state during each error pulse
    int proc_q[$];  // expected read address while convVld is high

    conv_addr_fsm #(
        .NB_ADDRESS (NB_ADDRESS),
        .NB_IMAGE   (NB_IMAGE),
        .N_CONV     (N_CONV),
        .LATENCIA   (LATENCIA),
        .NB_CH      (NB_CH)
    ) dut (
        .i_CLK         (clk),
        .i_reset       (rst_n),
        .i_imgLength   (img_len),
        .i_load        (load),
        .i_SoP         (sop),
        .i_valid       (valid),
        .o_writeAdd    (write_add),
        .o_readAdd     (read_add),
        .o_wrEn        (wr_en),
        .o_convVld     (conv_vld),
        .o_sopross     (sopross),
        .o_changeBlock (change_block),
        .o_EoP         (eop),
        .o_readCh      (read_ch),
        .o_err         (err),
        .o_state       (state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name);
        checks++;
        failures++;
        $display("FAIL %s: pulse seen with no expectation queued", name);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One rising edge of i_valid, held for 'hold' cycles then released for one.
    task automatic pulse(input int hold);
        valid = 1'b1;
        repeat (hold) tick();
        valid = 1'b0;
        tick();
    endtask

    // Scoreboard monitor: pops an expectation whenever the DUT presents an event.
    always @(negedge clk) begin
        if (mon_en) begin
            if (wr_en) begin
                if (wr_q.size() == 0) unexpected("wr_en");
                else check("write_add", int'(write_add), wr_q.pop_front());
            end
            if (change_block) begin
                if (cb_q.size() == 0) unexpected("change_block");
                else check("cb_state", int'(state), cb_q.pop_front());
            end
            if (err) begin
                if (err_q.size() == 0) unexpected("err");
                else check("err_state", int'(state), err_q.pop_front());
            end
            if (conv_vld) begin
                if (proc_q.size() == 0) unexpected("conv_vld");
                else check("proc_read_add", int'(read_add), proc_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n   = 1'b1;
        img_len = '0;
        load    = 1'b0;
        sop     = 1'b0;
        valid   = 1'b0;
        #2 rst_n = 1'b0;
        repeat (2) tick();
        check("rst_state", int'(state), 0);
        check("rst_wr_en", int'(wr_en), 0);
        check("rst_read_add", int'(read_add), 0);
        check("rst_eop", int'(eop), 0);
        check("rst_read_ch", int'(read_ch), 0);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        tick();

        // LOAD L=8; first edge held 5 cycles, length changed to 12 mid-pass.
        img_len = 8;
        load    = 1'b1;
        tick();
        load = 1'b0;
        check("load_state", int'(state), 1);
        for (int i = 0; i < 8; i++) wr_q.push_back(i);
        cb_q.push_back(0);
        for (int i = 0; i < 8; i++) begin
            if (i == 3) img_len = 12;
            pulse((i == 0) ? 5 : 1);
        end
        check("load_end_state", int'(state), 0);

        // Rejections: short length, then load and SoP together.
        img_len = 3;
        load    = 1'b1;
        err_q.push_back(0);
        tick();
        load = 1'b0;
        tick();
        check("short_len_state", int'(state), 0);
        img_len = 8;
        load    = 1'b1;
        sop     = 1'b1;
        err_q.push_back(0);
        tick();
        load = 1'b0;
        sop  = 1'b0;
        tick();
        check("both_req_state", int'(state), 0);

        // PROC L=8: read 0..7 then hold, writes 0..5 at c=5..10.
        for (int k = 0; k <= 10; k++) proc_q.push_back((k < 7) ? k : 7);
        for (int i = 0; i < 6; i++) wr_q.push_back(i);
        cb_q.push_back(3);
        sop = 1'b1;
        tick();
        check("proc_state", int'(state), 2);
        check("proc_sopross", int'(sopross), 1);
        repeat (3) tick();
        check("proc_read_add_c3", int'(read_add), 3);
        repeat (11) tick();
        check("done_state", int'(state), 3);
        check("done_eop", int'(eop), 1);
        check("done_conv_vld", int'(conv_vld), 0);
        check("done_sopross", int'(sopross), 0);
        sop = 1'b0;
        tick();
        check("after_done_state", int'(state), 0);

        // SoP while read-backs pending: ignored, no error.
        sop = 1'b1;
        repeat (3) tick();
        check("pending_sop_state", int'(state), 0);
        sop = 1'b0;
        tick();
        check("read_state", int'(state), 4);
        check("read_ch0", int'(read_ch), 0);
        check("read_add_start", int'(read_add), 0);

        // Read-back pass 0, then pass 1.
        cb_q.push_back(0);
        for (int i = 1; i <= 6; i++) begin
            pulse(1);
            if (i < 6) check("read0_add", int'(read_add), i);
        end
        check("read1_state", int'(state), 4);
        check("read1_ch", int'(read_ch), 1);
        check("read1_eop", int'(eop), 1);
        cb_q.push_back(0);
        for (int i = 1; i <= 6; i++) begin
            pulse(1);
            if (i < 6) check("read1_add", int'(read_add), i);
        end
        check("read_end_state", int'(state), 0);
        check("read_end_eop", int'(eop), 0);

        // Asynchronous reset mid-PROC, checked by hand.
        mon_en  = 1'b0;
        img_len = 8;
        sop     = 1'b1;
        tick();
        repeat (6) tick();
        check("pre_rst_wr_en", int'(wr_en), 1);
        #3 rst_n = 1'b0;
        #1;
        check("arst_state", int'(state), 0);
        check("arst_wr_en", int'(wr_en), 0);
        check("arst_write_add", int'(write_add), 0);
        check("arst_read_add", int'(read_add), 0);
        check("arst_conv_vld", int'(conv_vld), 0);
        check("arst_sopross", int'(sopross), 0);
        check("arst_eop", int'(eop), 0);
        sop = 1'b0;
        #3 rst_n = 1'b1;
        tick();
        mon_en = 1'b1;

        // Clean LOAD after reset, L=4.
        img_len = 4;
        load    = 1'b1;
        tick();
        load = 1'b0;
        check("reload_state", int'(state), 1);
        for (int i = 0; i < 4; i++) wr_q.push_back(i);
        cb_q.push_back(0);
        for (int i = 0; i < 4; i++) pulse(1);
        check("reload_end_state", int'(state), 0);
        tick();

        check("left_wr", wr_q.size(), 0);
        check("left_cb", cb_q.size(), 0);
        check("left_err", err_q.size(), 0);
        check("left_proc", proc_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
